addr_stride_reg: RTL and testbench

ADDR_STRIDE_REG -- requirements
Module: addr_stride_reg

---
 rtl/addr_stride_reg_pkg.sv | 16 +
 rtl/addr_chan.sv | 92 +++++++++
 rtl/addr_stride_reg.sv | 67 ++++++
 tb/tb_addr_stride_reg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/addr_stride_reg_pkg.sv
// Shared types and defaults for the strided address register bank.
// Holds the step mode encodings and default widths.
package addr_stride_reg_pkg;

  localparam int DEF_AW  = 32;
  localparam int DEF_NCH = 4;
  localparam int DEF_SW  = 8;

  typedef enum logic [1:0] {
    MODE_SAT  = 2'b00,
    MODE_WRAP = 2'b01,
    MODE_FREE = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

endpackage

// File: rtl/addr_chan.sv
// One address channel: base/cur/limit/stride/mode registers plus step logic.
// Ports: en_i selects this channel; wrap_o flags a wrapping step this cycle.
module addr_chan
  import addr_stride_reg_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int SW = DEF_SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          we_ar_i,
  input  logic          we_lim_i,
  input  logic          inc_i,
  input  logic [AW-1:0] addr_i,
  input  logic [SW-1:0] stride_i,
  input  logic [1:0]    mode_i,
  input  logic [AW-1:0] limit_i,
  output logic [AW-1:0] cur_o,
  output logic          at_limit_o,
  output logic          wrap_o
);

  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] lim_q, lim_d;
  logic [SW-1:0] stride_q, stride_d;
  mode_e         mode_q, mode_d;

  logic          ld;
  logic          step;
  logic [AW:0]   sum;
  logic          ovf;

  assign ld   = en_i & we_ar_i;
  // A load in the same cycle suppresses the step.
  assign step = en_i & inc_i & ~we_ar_i;
  assign sum  = {1'b0, cur_q} + {{(AW+1-SW){1'b0}}, stride_q};
  assign ovf  = sum[AW] | (sum[AW-1:0] > lim_q);

  always_comb begin
    cur_d    = cur_q;
    base_d   = base_q;
    lim_d    = lim_q;
    stride_d = stride_q;
    mode_d   = mode_q;
    wrap_o   = 1'b0;
    if (ld) begin
      cur_d    = addr_i;
      base_d   = addr_i;
      stride_d = stride_i;
      mode_d   = mode_e'(mode_i);
    end else if (step && stride_q != '0) begin
      unique case (mode_q)
        MODE_SAT: begin
          cur_d  = ovf ? lim_q : sum[AW-1:0];
          wrap_o = ovf;
        end
        MODE_WRAP: begin
          cur_d  = ovf ? base_q : sum[AW-1:0];
          wrap_o = ovf;
        end
        MODE_FREE, MODE_RSVD: begin
          cur_d  = sum[AW-1:0];
          wrap_o = sum[AW];
        end
      endcase
    end
    // Step above already used the old limit.
    if (en_i && we_lim_i) lim_d = limit_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q    <= '0;
      base_q   <= '0;
      lim_q    <= '1;
      stride_q <= SW'(1);
      mode_q   <= MODE_FREE;
    end else begin
      cur_q    <= cur_d;
      base_q   <= base_d;
      lim_q    <= lim_d;
      stride_q <= stride_d;
      mode_q   <= mode_d;
    end
  end

  assign cur_o      = cur_q;
  assign at_limit_o = (cur_q == lim_q);

endmodule

// File: rtl/addr_stride_reg.sv
// Bank of NCH strided address channels selected by ch_sel.
// Ports: load/limit/inc controls in; selected addr, all addrs, limit flags, wrap pulse out.
module addr_stride_reg
  import addr_stride_reg_pkg::*;
#(
  parameter int AW  = DEF_AW,
  parameter int NCH = DEF_NCH,
  parameter int SW  = DEF_SW,
  localparam int CW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     ch_sel,
  input  logic              we_AR,
  input  logic [AW-1:0]     i_addr,
  input  logic [SW-1:0]     i_stride,
  input  logic [1:0]        i_mode,
  input  logic              we_LIM,
  input  logic [AW-1:0]     i_limit,
  input  logic              inc,
  output logic [AW-1:0]     o_addr,
  output logic [NCH*AW-1:0] o_addr_all,
  output logic [NCH-1:0]    o_at_limit,
  output logic              o_wrap
);

  logic [NCH-1:0] en;
  logic [NCH-1:0] wrap_vec;
  logic [AW-1:0]  cur [NCH];
  logic           wrap_q;

  always_comb begin
    en = '0;
    for (int k = 0; k < NCH; k++) en[k] = (ch_sel == CW'(k));
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    addr_chan #(
      .AW(AW),
      .SW(SW)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en[k]),
      .we_ar_i   (we_AR),
      .we_lim_i  (we_LIM),
      .inc_i     (inc),
      .addr_i    (i_addr),
      .stride_i  (i_stride),
      .mode_i    (i_mode),
      .limit_i   (i_limit),
      .cur_o     (cur[k]),
      .at_limit_o(o_at_limit[k]),
      .wrap_o    (wrap_vec[k])
    );
    assign o_addr_all[k*AW +: AW] = cur[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= |wrap_vec;
  end

  assign o_addr = cur[ch_sel];
  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_addr_stride_reg.sv
// Scoreboard bench for addr_stride_reg: directed cases plus random traffic
// against an arithmetic reference model of the channel bank.
module tb_addr_stride_reg;

  localparam int AW  = 32;
  localparam int NCH = 4;
  localparam int SW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        ch_sel;
  logic              we_AR;
  logic [AW-1:0]     i_addr;
  logic [SW-1:0]     i_stride;
  logic [1:0]        i_mode;
  logic              we_LIM;
  logic [AW-1:0]     i_limit;
  logic              inc;
  logic [AW-1:0]     o_addr;
  logic [NCH*AW-1:0] o_addr_all;
  logic [NCH-1:0]    o_at_limit;
  logic              o_wrap;

  addr_stride_reg #(.AW(AW), .NCH(NCH), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_sel    (ch_sel),
    .we_AR     (we_AR),
    .i_addr    (i_addr),
    .i_stride  (i_stride),
    .i_mode    (i_mode),
    .we_LIM    (we_LIM),
    .i_limit   (i_limit),
    .inc       (inc),
    .o_addr    (o_addr),
    .o_addr_all(o_addr_all),
    .o_at_limit(o_at_limit),
    .o_wrap    (o_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH*AW-1:0] all;
    logic [NCH-1:0]    atl;
    logic              wrap;
    logic [AW-1:0]     addr;
    string             tag;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // reference model state
  longint m_cur[NCH], m_base[NCH], m_lim[NCH], m_str[NCH];
  int     m_mode[NCH];

  task automatic chk(string name, logic [NCH*AW-1:0] act, logic [NCH*AW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_cur[k] = 0; m_base[k] = 0; m_lim[k] = 64'hFFFF_FFFF;
      m_str[k] = 1; m_mode[k] = 2;
    end
  endtask

  // one clock of stimulus; expected post-edge outputs go to the scoreboard
  task automatic cyc(string tag, int ch, bit ar, longint a, int s, int md,
                     bit lw, longint l, bit in);
    exp_t e;
    bit w;
    longint sum;
    @(negedge clk);
    ch_sel = 2'(ch); we_AR = ar; i_addr = AW'(a); i_stride = SW'(s);
    i_mode = 2'(md); we_LIM = lw; i_limit = AW'(l); inc = in;
    w = 0;
    if (ar) begin
      m_cur[ch] = a; m_base[ch] = a; m_str[ch] = s; m_mode[ch] = md;
    end else if (in && m_str[ch] != 0) begin
      sum = m_cur[ch] + m_str[ch];
      if (m_mode[ch] == 0 || m_mode[ch] == 1) begin
        if (sum > 64'hFFFF_FFFF || sum > m_lim[ch]) begin
          w = 1;
          m_cur[ch] = (m_mode[ch] == 0) ? m_lim[ch] : m_base[ch];
        end else m_cur[ch] = sum;
      end else begin
        w = (sum > 64'hFFFF_FFFF);
        m_cur[ch] = sum % 64'h1_0000_0000;
      end
    end
    if (lw) m_lim[ch] = l;
    for (int k = 0; k < NCH; k++) begin
      e.all[k*AW +: AW] = AW'(m_cur[k]);
      e.atl[k] = (m_cur[k] == m_lim[k]);
    end
    e.wrap = w;
    e.addr = AW'(m_cur[ch]);
    e.tag  = tag;
    q.push_back(e);
  endtask

  task automatic idle(string tag, int ch);
    cyc(tag, ch, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: compares the DUT outputs after each edge with the next expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".addr_all"}, o_addr_all, e.all);
        chk({e.tag, ".at_limit"}, NCH*AW'(o_at_limit), NCH*AW'(e.atl));
        chk({e.tag, ".wrap"}, NCH*AW'(o_wrap), NCH*AW'(e.wrap));
        chk({e.tag, ".addr"}, NCH*AW'(o_addr), NCH*AW'(e.addr));
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, ".addr"}, NCH*AW'(o_addr), '0);
    chk({tag, ".addr_all"}, o_addr_all, '0);
    chk({tag, ".at_limit"}, NCH*AW'(o_at_limit), '0);
    chk({tag, ".wrap"}, NCH*AW'(o_wrap), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ch, md;
    longint a, l;
    rst = 1; ch_sel = 0; we_AR = 0; i_addr = 0; i_stride = 0; i_mode = 0;
    we_LIM = 0; i_limit = 0; inc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;

    // ch0 default stride 1 FREE
    repeat (3) cyc("ch0_inc", 0, 0, 0, 0, 0, 0, 0, 1);

    // ch1 WRAP with limit 0x120
    cyc("ch1_load", 1, 1, 'h100, 'h10, 1, 0, 0, 0);
    cyc("ch1_lim", 1, 0, 0, 0, 0, 1, 'h120, 0);
    repeat (3) cyc("ch1_inc", 1, 0, 0, 0, 0, 0, 0, 1);

    // ch2 SAT with limit 0x10
    cyc("ch2_load", 2, 1, 0, 7, 0, 1, 'h10, 0);
    repeat (5) cyc("ch2_inc", 2, 0, 0, 0, 0, 0, 0, 1);

    // ch3 FREE carry out
    cyc("ch3_load", 3, 1, 'hFFFF_FFF0, 'h20, 2, 0, 0, 0);
    cyc("ch3_inc", 3, 0, 0, 0, 0, 0, 0, 1);

    // load beats inc
    cyc("ch1_ld_inc", 1, 1, 'h500, 'h10, 1, 0, 0, 1);
    idle("idle", 0);

    // limit update together with inc, then limit below cur
    cyc("ch1_lim_inc", 1, 0, 0, 0, 0, 1, 'h505, 1);
    cyc("ch1_lim_lo", 1, 0, 0, 0, 0, 1, 'h400, 0);
    cyc("ch1_inc_ovf", 1, 0, 0, 0, 0, 0, 0, 1);

    // stride 0 never moves or wraps
    cyc("ch2_s0", 2, 1, 'h30, 0, 0, 1, 'h10, 0);
    cyc("ch2_s0_inc", 2, 0, 0, 0, 0, 0, 0, 1);

    // reserved mode acts as FREE
    cyc("ch0_rsvd", 0, 1, 'hFFFF_FFFF, 1, 3, 1, 5, 0);
    cyc("ch0_rsvd_inc", 0, 0, 0, 0, 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      ch = $urandom_range(0, NCH - 1);
      md = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = longint'($urandom);
      else a = $urandom_range(0, 400);
      if ($urandom_range(0, 3) == 0) l = longint'($urandom);
      else l = $urandom_range(0, 500);
      cyc("rand", ch, $urandom_range(0, 5) == 0, a, $urandom_range(0, 255), md,
          $urandom_range(0, 5) == 0, l, $urandom_range(0, 1) == 1);
    end

    // async reset while ch1 is wrap-stepping
    cyc("pre_rst_load", 1, 1, 'h100, 'h10, 1, 1, 'h120, 0);
    cyc("pre_rst_inc", 1, 0, 0, 0, 0, 0, 0, 1);
    cyc("pre_rst_inc", 1, 0, 0, 0, 0, 0, 0, 1);
    cyc("pre_rst_inc", 1, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    inc = 1;
    #2 rst = 1;
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    #1 check_reset_outputs("rst_hold");
    @(negedge clk);
    rst = 0;
    inc = 0;
    model_reset();
    cyc("post_rst_inc", 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("post_rst_inc1", 1, 0, 0, 0, 0, 0, 0, 1);
    idle("final", 1);

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
